// File: rtl/jpeg_output_block_writer.sv
// Write-side sequencer for one JPEG output sample RAM: admits a 64-sample block only when the RAM has room,
// then pushes exactly 64 samples. Define JPEG_OUTPUT_WRITER_TRANSPOSE_EN for column-major (transposed) write indices.
module jpeg_output_block_writer #(
   parameter int RAM_DEPTH = 512
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        valid_i,
   input  logic [31:0] data_i,
   output logic        ready_o,
   input  logic [31:0] level_i,
   output logic [5:0]  wr_idx_o,
   output logic [31:0] data_o,
   output logic        push_o,
   output logic        block_done_o,
   output logic [15:0] blocks_o
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [31:0] SPACE_LIMIT = 32'(RAM_DEPTH - 64);

   state_t     state_q;
   logic [5:0] idx_q;

   // Flush must win over a same-cycle sample so the RAM never sees a push it is discarding.
   assign push_o = valid_i && ready_o && !flush_i;
   assign data_o = data_i;

`ifdef JPEG_OUTPUT_WRITER_TRANSPOSE_EN
   assign wr_idx_o = {idx_q[2:0], idx_q[5:3]};
`else
   assign wr_idx_o = idx_q;
`endif

   // DONE is a deliberate gap cycle so level_i reflects the last push before the next space check.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state_q      <= IDLE;
         idx_q        <= 6'd0;
         ready_o      <= 1'b0;
         block_done_o <= 1'b0;
         blocks_o     <= 16'd0;
      end else begin
         block_done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_i && (level_i <= SPACE_LIMIT)) begin
                  state_q <= WRITE;
                  ready_o <= 1'b1;
               end
            end
            WRITE: begin
               if (push_o) begin
                  idx_q <= idx_q + 6'd1;
                  if (idx_q == 6'd63) begin
                     state_q      <= DONE;
                     ready_o      <= 1'b0;
                     block_done_o <= 1'b1;
                     blocks_o     <= blocks_o + 16'd1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/jpeg_output_block_writer.md
# jpeg_output_block_writer

Write-side sequencer for the JPEG output sample RAMs: accepts the IDCT result stream one 32-bit sample at a time, assembles samples into complete 64-sample blocks, and drives the RAM write port (`wr_idx`, `data`, `push`). It guarantees that a block is only started when the RAM has room for all 64 samples, and that every started block is pushed exactly 64 times, so the RAM's block base pointer stays aligned. It sits between the IDCT and each per-component output RAM (Y/Cb/Cr), one instance per RAM.

## Interface
Parameters:
- `RAM_DEPTH`, default 512: output RAM capacity in samples; must be a multiple of 64 and at least 64.

Ports:
- `clk_i` input 1: clock; single clock domain.
- `rst_i` input 1: synchronous, active-high reset.
- `flush_i` input 1: synchronous flush; same effect as reset on all state of this block.
- `valid_i` input 1: IDCT sample valid.
- `data_i` input 32: IDCT sample.
- `ready_o` output 1: sample accepted when `valid_i && ready_o`.
- `level_i` input 32: current RAM occupancy, connected to the RAM's `level_o`.
- `wr_idx_o` output 6: RAM write index within the current block.
- `data_o` output 32: RAM write data.
- `push_o` output 1: RAM write strobe, one sample per cycle.
- `block_done_o` output 1: one-cycle pulse after the 64th push of a block.
- `blocks_o` output 16: count of completed blocks since reset or flush; wraps at 65535 to 0.

## Operation
- FSM states: IDLE, WRITE, DONE. Reset and flush force IDLE.
- IDLE: `ready_o`=0. Go to WRITE when `valid_i`=1 and `level_i <= RAM_DEPTH-64`. Otherwise stay in IDLE. This is the space check.
- WRITE: `ready_o`=1. Each accepted sample causes one push in the same cycle. Combinational write path: `push_o = valid_i && ready_o`, `data_o = data_i`, and `wr_idx_o` derived from the 6-bit sample counter `idx_q`.
- `idx_q` increments on each push. On the push with `idx_q`=63, `idx_q` wraps to 0 and the FSM goes to DONE.
- `valid_i`=0 while in WRITE stalls without a push. The FSM does not leave WRITE until the block is complete.
- DONE: `ready_o`=0. `block_done_o`=1 for this one cycle and `blocks_o` increments. Next state is IDLE unconditionally. This gap cycle lets `level_i` reflect the final push before the next space check.
- The RAM consumer may pop while a block is being written. A pop only lowers `level_i`, so a block admitted by the space check never overflows the RAM.
- Flush or reset in mid-block: the partial block is discarded, `idx_q` is set to 0, and `blocks_o` is set to 0. Flush is asserted to the RAM in the same cycle by the top level.
- When flush and a sample arrive in the same cycle, flush wins: `push_o` is forced to 0 while `flush_i`=1.

## Timing
- Reset/flush values: `ready_o`=0, `push_o`=0, `wr_idx_o`=0, `data_o`=`data_i` (pass-through, qualified by `push_o`), `block_done_o`=0, `blocks_o`=0.
- Admission latency: IDLE with `valid_i`=1 and space available → `ready_o`=1 on the next cycle.
- Zero-latency write: a sample accepted in cycle t is pushed to the RAM in cycle t.
- Minimum block period is 66 cycles: 1 IDLE, 64 WRITE, 1 DONE.
- `level_i` is sampled only in IDLE.

## Configuration
- `JPEG_OUTPUT_WRITER_TRANSPOSE_EN` defined: the IDCT delivers samples in column-major order, so `wr_idx_o = {idx_q[2:0], idx_q[5:3]}` (transposed).
- Not defined: `wr_idx_o = idx_q` (row-major pass-through).
- All other behaviour is identical in both builds.

## Test plan
- Reset, then 64 contiguous valid samples 0..63 with `level_i`=0: `ready_o` rises 1 cycle after `valid_i`; 64 pushes with `wr_idx_o` 0..63 (transpose off) or 0,8,16,…,63 (transpose on); `block_done_o` pulses once; `blocks_o`=1.
- `level_i`=449 with `valid_i` held high: `ready_o` stays 0 and no push occurs. Drop `level_i` to 448: WRITE is entered on the next cycle.
- Random `valid_i` gaps at 50% inside a block: exactly 64 pushes, `idx_q` never skips, and `block_done_o` fires only after the 64th push.
- Assert `flush_i` after 20 pushes: `push_o`=0 in the flush cycle, FSM returns to IDLE, and the next block starts at `wr_idx_o`=0 with `blocks_o`=0.
- 9 back-to-back blocks with `RAM_DEPTH`=512, where the consumer pops only after block 8: block 9 is held in IDLE until `level_i` ≤ 448, and the RAM never exceeds 512 entries.
- 65536 blocks with a fast consumer: `blocks_o` wraps 65535→0.
